// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point denormalizer slice.
//   exp_width()  : exponent field width for a given mantissa width, clog2(WIDTH+1)
//   bfp_state_e  : block framing states (BLK_START, BLK_BODY)
//   ROUND_EN     : 1 when built with BFP_DENORM_ROUND_EN (round-half-up),
//                  0 otherwise (plain truncation / floor)
// Configuration macro: BFP_DENORM_ROUND_EN
package bfp_pkg;

  function automatic int exp_width(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic [0:0] {
    BLK_START = 1'b0,
    BLK_BODY  = 1'b1
  } bfp_state_e;

`ifdef BFP_DENORM_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

endpackage

// File: rtl/bfp_shift_right.sv
// Per-lane combinational right shift that restores the original scale of a
// normalized mantissa.
// Ports:
//   sample   in  WIDTH  normalized mantissa
//   exponent in  EXP_W  shift amount; values above WIDTH act as WIDTH
//   result   out WIDTH  shifted sample
// IS_SIGNED=1 shifts arithmetically, IS_SIGNED=0 zero-fills.
// With BFP_DENORM_ROUND_EN (see bfp_pkg) 2^(e-1) is added before the shift.
module bfp_shift_right
  import bfp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IS_SIGNED = 1,
  parameter int EXP_W     = exp_width(WIDTH)
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [EXP_W-1:0] exponent,
  output logic [WIDTH-1:0] result
);

  localparam logic [EXP_W-1:0] E_MAX = EXP_W'(WIDTH);
  localparam logic [WIDTH:0]   ONE   = (WIDTH + 1)'(1);

  logic [EXP_W-1:0] e_c;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   rnd;
  logic [WIDTH:0]   sum;

  // The sample is widened by one bit so the rounding increment can never
  // overflow; the top bit is the sign in signed mode and zero otherwise.
  always_comb begin
    e_c = (exponent > E_MAX) ? E_MAX : exponent;
    ext = {((IS_SIGNED != 0) & sample[WIDTH-1]), sample};
    rnd = '0;
    if (ROUND_EN && (e_c != '0)) begin
      rnd = ONE << (e_c - EXP_W'(1));
    end
    sum = ext + rnd;
    if (IS_SIGNED != 0) begin
      result = WIDTH'($signed(sum) >>> e_c);
    end else begin
      result = WIDTH'(sum >> e_c);
    end
    // A full-width shift with rounding always lands on zero by definition.
    if (ROUND_EN && (e_c == E_MAX)) begin
      result = '0;
    end
  end

endmodule

// File: rtl/bfp_denormalizer.sv
// Block-floating-point decoder. Each accepted I/Q pair is shifted right by the
// block exponent latched on the first sample of its block; later samples whose
// exponent_in disagrees are flagged but still use the latched exponent.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_in, q_in           normalized mantissas (WIDTH)
//   exponent_in          block exponent (EXP_W = clog2(WIDTH+1))
//   valid_in / ready_in  input handshake, ready_in = !valid_out || ready_out
//   i_out, q_out         denormalized samples, registered (1 cycle latency)
//   valid_out/ready_out  output handshake
//   last_out             final sample of a block (index BLOCK_SIZE-1)
//   exp_err_out          sample exponent differed from the block exponent
// Configuration macro: BFP_DENORM_ROUND_EN (round-half-up instead of truncate).
module bfp_denormalizer
  import bfp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 256,
  parameter int IS_SIGNED  = 1,
  parameter int EXP_W      = exp_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [EXP_W-1:0] exponent_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] i_out,
  output logic [WIDTH-1:0] q_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             last_out,
  output logic             exp_err_out
);

  localparam int CNT_W = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

  bfp_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [EXP_W-1:0] exp_q;

  logic             accept;
  logic [EXP_W-1:0] use_exp;
  logic             smp_err;
  logic             smp_last;
  logic [WIDTH-1:0] i_shift;
  logic [WIDTH-1:0] q_shift;

  assign ready_in = !valid_out || ready_out;
  assign accept   = valid_in && ready_in;

  // The first sample of a block uses its own exponent directly; every later
  // sample uses the latched block exponent and is compared against it.
  always_comb begin
    use_exp  = exp_q;
    smp_err  = 1'b0;
    smp_last = 1'b0;
    if (state == BLK_START) begin
      use_exp = exponent_in;
    end else begin
      smp_err  = (exponent_in != exp_q);
      smp_last = (cnt == CNT_LAST);
    end
  end

  bfp_shift_right #(
    .WIDTH    (WIDTH),
    .IS_SIGNED(IS_SIGNED),
    .EXP_W    (EXP_W)
  ) u_shift_i (
    .sample  (i_in),
    .exponent(use_exp),
    .result  (i_shift)
  );

  bfp_shift_right #(
    .WIDTH    (WIDTH),
    .IS_SIGNED(IS_SIGNED),
    .EXP_W    (EXP_W)
  ) u_shift_q (
    .sample  (q_in),
    .exponent(use_exp),
    .result  (q_shift)
  );

  // Block framing: only accepted samples advance the counter and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLK_START;
      cnt   <= '0;
      exp_q <= '0;
    end else if (accept) begin
      if (state == BLK_START) begin
        exp_q <= exponent_in;
        cnt   <= CNT_W'(1);
        state <= BLK_BODY;
      end else if (smp_last) begin
        cnt   <= '0;
        state <= BLK_START;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output register: loads on accept, drops valid after a handshake with no
  // replacement, and otherwise holds everything stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out       <= '0;
      q_out       <= '0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      exp_err_out <= 1'b0;
    end else if (accept) begin
      i_out       <= i_shift;
      q_out       <= q_shift;
      valid_out   <= 1'b1;
      last_out    <= smp_last;
      exp_err_out <= smp_err;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfp_denormalizer.sv
// Self-checking bench for bfp_denormalizer (WIDTH=16, BLOCK_SIZE=4, signed).
// A block-level model predicts every output from the shift/framing rules; a
// negedge monitor compares the DUT against it each cycle and logs handshakes,
// and directed scenarios pin the model with hand-computed literals.
// Honors BFP_DENORM_ROUND_EN for the rounding expectations.
module tb_bfp_denormalizer;

  localparam int W  = 16;
  localparam int BS = 4;
  localparam int EW = 5;

  typedef struct {
    logic [W-1:0] i;
    logic [W-1:0] q;
    logic         last;
    logic         err;
  } obs_t;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  i_in;
  logic [W-1:0]  q_in;
  logic [EW-1:0] exponent_in;
  logic          valid_in;
  logic          ready_in;
  logic [W-1:0]  i_out;
  logic [W-1:0]  q_out;
  logic          valid_out;
  logic          ready_out;
  logic          last_out;
  logic          exp_err_out;

  int checks   = 0;
  int failures = 0;

  obs_t exp_fifo[$];
  obs_t obs_log[$];
  int   blk_idx = 0;
  int   blk_exp = 0;

  bfp_denormalizer #(
    .WIDTH     (W),
    .BLOCK_SIZE(BS),
    .IS_SIGNED (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in       (i_in),
    .q_in       (q_in),
    .exponent_in(exponent_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .i_out      (i_out),
    .q_out      (q_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .last_out   (last_out),
    .exp_err_out(exp_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scale restoration in plain integer arithmetic: floor(v / 2^e), or
  // floor((v + 2^(e-1)) / 2^e) when rounding; exponent clamped to W.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] x, input int e);
    int v;
    int ee;
    ee = (e > W) ? W : e;
    v  = $signed(x);
`ifdef BFP_DENORM_ROUND_EN
    if (ee >= W) return '0;
    if (ee > 0) v = v + (1 << (ee - 1));
`endif
    v = v >>> ee;
    return v[W-1:0];
  endfunction

  // Predict what an accepted sample must produce, tracking position in block.
  function automatic obs_t model_sample(input logic [W-1:0] i, input logic [W-1:0] q,
                                        input int e);
    obs_t o;
    int   eu;
    if (blk_idx == 0) begin
      blk_exp = e;
      o.err   = 1'b0;
    end else begin
      o.err = (e != blk_exp);
    end
    eu      = blk_exp;
    o.i     = model_shift(i, eu);
    o.q     = model_shift(q, eu);
    o.last  = (blk_idx == BS - 1);
    blk_idx = (blk_idx + 1) % BS;
    return o;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_fifo.delete();
      blk_idx = 0;
      checks++;
      if (valid_out || last_out || exp_err_out || i_out != '0 || q_out != '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: valid=%b last=%b err=%b i=%h q=%h, required all 0",
                 valid_out, last_out, exp_err_out, i_out, q_out);
      end
    end else begin
      checks++;
      if (valid_out !== (exp_fifo.size() != 0)) begin
        failures++;
        $display("[TB] FAIL valid_out: got %b, required %b", valid_out, exp_fifo.size() != 0);
      end
      checks++;
      if (ready_in !== ((exp_fifo.size() == 0) || ready_out)) begin
        failures++;
        $display("[TB] FAIL ready_in: got %b, required %b", ready_in,
                 (exp_fifo.size() == 0) || ready_out);
      end
      if (valid_out && exp_fifo.size() != 0) begin
        checks++;
        if (i_out !== exp_fifo[0].i || q_out !== exp_fifo[0].q ||
            last_out !== exp_fifo[0].last || exp_err_out !== exp_fifo[0].err) begin
          failures++;
          $display("[TB] FAIL model_output: got i=%h q=%h last=%b err=%b, required i=%h q=%h last=%b err=%b",
                   i_out, q_out, last_out, exp_err_out, exp_fifo[0].i, exp_fifo[0].q,
                   exp_fifo[0].last, exp_fifo[0].err);
        end
        if (ready_out) begin
          obs_t o;
          o.i = i_out; o.q = q_out; o.last = last_out; o.err = exp_err_out;
          obs_log.push_back(o);
          void'(exp_fifo.pop_front());
        end
      end
      if (valid_in && ready_in) begin
        exp_fifo.push_back(model_sample(i_in, q_in, int'(exponent_in)));
      end
    end
  end

  task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Compare one logged output handshake against hand-computed literals.
  task automatic checkOutput(input string name, input int idx, input logic [W-1:0] ei,
                             input logic [W-1:0] eq, input logic el, input logic ee);
    checks++;
    if (idx >= obs_log.size()) begin
      failures++;
      $display("[TB] FAIL %s: output %0d missing, only %0d observed", name, idx, obs_log.size());
    end else if (obs_log[idx].i !== ei || obs_log[idx].q !== eq ||
                 obs_log[idx].last !== el || obs_log[idx].err !== ee) begin
      failures++;
      $display("[TB] FAIL %s: got i=%h q=%h last=%b err=%b, required i=%h q=%h last=%b err=%b",
               name, obs_log[idx].i, obs_log[idx].q, obs_log[idx].last, obs_log[idx].err,
               ei, eq, el, ee);
    end
  endtask

  // Present one sample and hold it until accepted (bounded), then release.
  task automatic applyStimulus(input logic [W-1:0] i, input logic [W-1:0] q,
                               input logic [EW-1:0] e);
    int guard;
    guard       = 0;
    i_in        = i;
    q_in        = q;
    exponent_in = e;
    valid_in    = 1'b1;
    @(negedge clk);
    while (!ready_in && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_in) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: ready_in=%b after %0d cycles, required 1", ready_in, guard);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    ready_out = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base;
    rst_n       = 1'b0;
    i_in        = '0;
    q_in        = '0;
    exponent_in = '0;
    valid_in    = 1'b0;
    ready_out   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_i_out", i_out, 16'h0000);
    checkValue("reset_valid_out", {15'd0, valid_out}, 16'h0000);
    rst_n = 1'b1;
    #1;
    checkValue("ready_in_after_reset", {15'd0, ready_in}, 16'h0001);
    @(posedge clk);
    #1;

    $display("[TB] basic shift");
    base = obs_log.size();
    applyStimulus(16'h0100, 16'hFF00, 5'd3);
    checkValue("basic_valid_latency", {15'd0, valid_out}, 16'h0001);
    checkValue("basic_i", i_out, 16'h0020);
    checkValue("basic_q", q_out, 16'hFFE0);
    applyStimulus(16'h0008, 16'h0000, 5'd3);
    applyStimulus(16'h0010, 16'h0000, 5'd3);
    applyStimulus(16'h0018, 16'h0000, 5'd3);
    drain();
    checkOutput("basic_out3", base + 3, 16'h0003, 16'h0000, 1'b1, 1'b0);

    $display("[TB] block framing");
    base = obs_log.size();
    applyStimulus(16'h1234, 16'h5555, 5'd0);
    applyStimulus(16'h8001, 16'h5555, 5'd0);
    applyStimulus(16'h00FF, 16'h5555, 5'd0);
    applyStimulus(16'hABCD, 16'h5555, 5'd0);
    applyStimulus(16'h0100, 16'h0040, 5'd1);
    applyStimulus(16'h0200, 16'h0040, 5'd1);
    applyStimulus(16'h8000, 16'h0040, 5'd1);
    applyStimulus(16'h0002, 16'h0040, 5'd1);
    drain();
    checkOutput("frame_s1", base + 0, 16'h1234, 16'h5555, 1'b0, 1'b0);
    checkOutput("frame_s2", base + 1, 16'h8001, 16'h5555, 1'b0, 1'b0);
    checkOutput("frame_s3", base + 2, 16'h00FF, 16'h5555, 1'b0, 1'b0);
    checkOutput("frame_s4", base + 3, 16'hABCD, 16'h5555, 1'b1, 1'b0);
    checkOutput("frame_s5", base + 4, 16'h0080, 16'h0020, 1'b0, 1'b0);
    checkOutput("frame_s6", base + 5, 16'h0100, 16'h0020, 1'b0, 1'b0);
    checkOutput("frame_s7", base + 6, 16'hC000, 16'h0020, 1'b0, 1'b0);
    checkOutput("frame_s8", base + 7, 16'h0001, 16'h0020, 1'b1, 1'b0);

    $display("[TB] exponent mismatch");
    base = obs_log.size();
    applyStimulus(16'h0040, 16'h0040, 5'd2);
    applyStimulus(16'h0040, 16'h0040, 5'd5);
    applyStimulus(16'h0040, 16'h0040, 5'd2);
    applyStimulus(16'h0040, 16'h0040, 5'd2);
    drain();
    checkOutput("mismatch_s1", base + 0, 16'h0010, 16'h0010, 1'b0, 1'b0);
    checkOutput("mismatch_s2", base + 1, 16'h0010, 16'h0010, 1'b0, 1'b1);
    checkOutput("mismatch_s3", base + 2, 16'h0010, 16'h0010, 1'b0, 1'b0);
    checkOutput("mismatch_s4", base + 3, 16'h0010, 16'h0010, 1'b1, 1'b0);

    $display("[TB] backpressure");
    base = obs_log.size();
    fork
      begin
        applyStimulus(16'h0010, 16'h0000, 5'd1);
        applyStimulus(16'h0020, 16'h0000, 5'd1);
        applyStimulus(16'h0030, 16'h0000, 5'd1);
        applyStimulus(16'h0040, 16'h0000, 5'd1);
      end
      begin
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain();
    checkValue("bp_count", 16'(obs_log.size() - base), 16'd4);
    checkOutput("bp_s1", base + 0, 16'h0008, 16'h0000, 1'b0, 1'b0);
    checkOutput("bp_s2", base + 1, 16'h0010, 16'h0000, 1'b0, 1'b0);
    checkOutput("bp_s3", base + 2, 16'h0018, 16'h0000, 1'b0, 1'b0);
    checkOutput("bp_s4", base + 3, 16'h0020, 16'h0000, 1'b1, 1'b0);

    $display("[TB] rounding");
    base = obs_log.size();
    applyStimulus(16'h0007, 16'hFFFA, 5'd2);
    applyStimulus(16'hFFFA, 16'h0007, 5'd2);
    applyStimulus(16'h0000, 16'h0000, 5'd2);
    applyStimulus(16'h0000, 16'h0000, 5'd2);
    drain();
`ifdef BFP_DENORM_ROUND_EN
    checkOutput("round_s1", base + 0, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("round_s2", base + 1, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
`else
    checkOutput("round_s1", base + 0, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    checkOutput("round_s2", base + 1, 16'hFFFE, 16'h0001, 1'b0, 1'b0);
`endif

    $display("[TB] large exponent and mid-block reset");
    base = obs_log.size();
    applyStimulus(16'h8000, 16'h0001, 5'd16);
    applyStimulus(16'h7FFF, 16'h8000, 5'd16);
    checkValue("large_i_pos", i_out, 16'h0000);
`ifdef BFP_DENORM_ROUND_EN
    checkValue("large_q_neg", q_out, 16'h0000);
`else
    checkValue("large_q_neg", q_out, 16'hFFFF);
`endif
    rst_n = 1'b0;
    #1;
    checkValue("midreset_valid", {15'd0, valid_out}, 16'h0000);
    checkValue("midreset_i", i_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef BFP_DENORM_ROUND_EN
    checkOutput("large_s1", base + 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
`else
    checkOutput("large_s1", base + 0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
`endif
    base = obs_log.size();
    applyStimulus(16'h0001, 16'h0000, 5'd0);
    applyStimulus(16'h0002, 16'h0000, 5'd0);
    applyStimulus(16'h0003, 16'h0000, 5'd0);
    applyStimulus(16'h0004, 16'h0000, 5'd0);
    drain();
    checkOutput("post_reset_s1", base + 0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    checkOutput("post_reset_s2", base + 1, 16'h0002, 16'h0000, 1'b0, 1'b0);
    checkOutput("post_reset_s3", base + 2, 16'h0003, 16'h0000, 1'b0, 1'b0);
    checkOutput("post_reset_s4", base + 3, 16'h0004, 16'h0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
